// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the ID/EX stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } state_t;

    localparam int unsigned CTRL_W_DEF = 10;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds when neither clr nor inc.
module sat_counter #(
    parameter int unsigned   W   = 8,
    parameter logic [W-1:0]  MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Load-use stall / branch flush controller owning the ID/EX control register.
// Optional perf counters enabled by defining STALL_PERF_EN.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W       = CTRL_W_DEF,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hz_stall,
    input  logic              br_taken,
    input  logic              mem_busy,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              ex_mem_en,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              id_ex_valid,
    output logic              stall_err,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam int unsigned     RL_W   = $clog2(MAX_STALL + 1);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL);
    localparam logic [RL_W-1:0] RL_ERR = RL_W'(MAX_STALL - 1);
    localparam logic [1:0]      FLUSH_RELOAD =
        (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    state_t           state, state_nxt;
    logic [1:0]       flush_cnt, flush_cnt_nxt;
    logic [RL_W-1:0]  run_len;
    logic             br_go, flush_go, stall_go, run_go;

    // Exactly one of the *_go strobes fires per unfrozen cycle; none while frozen or in reset.
    always_comb begin
        br_go         = 1'b0;
        flush_go      = 1'b0;
        stall_go      = 1'b0;
        run_go        = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        ex_mem_en     = 1'b0;
        if_id_flush   = 1'b0;
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (!rst_n || mem_busy) begin
            // hold everything
        end else if (br_taken) begin
            br_go         = 1'b1;
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            ex_mem_en     = 1'b1;
            if_id_flush   = 1'b1;
            state_nxt     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            flush_cnt_nxt = FLUSH_RELOAD;
        end else if (state == FLUSH) begin
            flush_go    = 1'b1;
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if_id_flush = 1'b1;
            if (flush_cnt == 2'd0) begin
                state_nxt = RUN;
            end else begin
                flush_cnt_nxt = flush_cnt - 2'd1;
            end
        end else if (hz_stall) begin
            stall_go  = 1'b1;
            ex_mem_en = 1'b1;
            state_nxt = STALL;
        end else begin
            run_go    = 1'b1;
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            ex_mem_en = 1'b1;
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            flush_cnt   <= '0;
            ctrl_out    <= '0;
            id_ex_valid <= 1'b0;
            stall_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (run_go) begin
                ctrl_out    <= ctrl_in;
                id_ex_valid <= 1'b1;
            end else if (br_go || flush_go || stall_go) begin
                ctrl_out    <= CTRL_W'(CTRL_NOP);
                id_ex_valid <= 1'b0;
            end
            // Fires on the stall edge that brings run_len up to MAX_STALL.
            if (stall_go && (run_len >= RL_ERR)) begin
                stall_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W   (RL_W),
        .MAX (RL_MAX)
    ) u_run_len (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_go || br_go || flush_go),
        .inc   (stall_go),
        .cnt   (run_len)
    );

`ifdef STALL_PERF_EN
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (stall_go),
        .cnt   (stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_events (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (br_go),
        .cnt   (flush_events)
    );
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table plus multi-cycle corner sequences.
module tb_pipe_stall_ctrl;

`ifdef STALL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    typedef struct {
        logic       hz;
        logic       br;
        logic       mb;
        logic [9:0] ctrl;
        logic [3:0] exp_en;    // {pc_en, if_id_en, if_id_flush, ex_mem_en}
        logic [9:0] exp_ctrl;  // ctrl_out after the edge
        logic       exp_v;     // id_ex_valid after the edge
    } vec_t;

    typedef struct {
        logic [9:0] ctrl;
        logic       v;
    } reg_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hz, br, mb;
    logic [9:0]  ctrl_in;
    logic        pc_en, if_id_en, if_id_flush, ex_mem_en, id_ex_valid, stall_err;
    logic [9:0]  ctrl_out;
    logic [15:0] stall_cycles, flush_events;

    logic        hz_b, br_b;
    logic        pc_en_b, if_id_en_b, if_id_flush_b, ex_mem_en_b, id_ex_valid_b, stall_err_b;
    logic [9:0]  ctrl_out_b;
    logic [15:0] stall_cycles_b, flush_events_b;

    int checks   = 0;
    int failures = 0;
    reg_exp_t sb[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .CTRL_W       (10),
        .FLUSH_CYCLES (1),
        .MAX_STALL    (4),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz_stall     (hz),
        .br_taken     (br),
        .mem_busy     (mb),
        .ctrl_in      (ctrl_in),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .ex_mem_en    (ex_mem_en),
        .ctrl_out     (ctrl_out),
        .id_ex_valid  (id_ex_valid),
        .stall_err    (stall_err),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    pipe_stall_ctrl #(
        .CTRL_W       (10),
        .FLUSH_CYCLES (3),
        .MAX_STALL    (4),
        .CNT_W        (16)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz_stall     (hz_b),
        .br_taken     (br_b),
        .mem_busy     (1'b0),
        .ctrl_in      (10'h0FF),
        .pc_en        (pc_en_b),
        .if_id_en     (if_id_en_b),
        .if_id_flush  (if_id_flush_b),
        .ex_mem_en    (ex_mem_en_b),
        .ctrl_out     (ctrl_out_b),
        .id_ex_valid  (id_ex_valid_b),
        .stall_err    (stall_err_b),
        .stall_cycles (stall_cycles_b),
        .flush_events (flush_events_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle on instance A: drive at negedge, check comb outputs, score registered ones after the edge.
    task automatic step(input vec_t v, input string nm);
        reg_exp_t e;
        @(negedge clk);
        hz = v.hz; br = v.br; mb = v.mb; ctrl_in = v.ctrl;
        #1;
        check({nm, ".en"}, {28'd0, pc_en, if_id_en, if_id_flush, ex_mem_en}, {28'd0, v.exp_en});
        sb.push_back('{ctrl: v.exp_ctrl, v: v.exp_v});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({nm, ".ctrl_out"}, {22'd0, ctrl_out}, {22'd0, e.ctrl});
        check({nm, ".valid"}, {31'd0, id_ex_valid}, {31'd0, e.v});
    endtask

    function automatic vec_t mk(input logic h, input logic b, input logic m, input logic [9:0] c,
                                input logic [3:0] en, input logic [9:0] ec, input logic ev);
        vec_t v;
        v.hz = h; v.br = b; v.mb = m; v.ctrl = c;
        v.exp_en = en; v.exp_ctrl = ec; v.exp_v = ev;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        hz = 0; br = 0; mb = 0; ctrl_in = '0; hz_b = 0; br_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] exp_fl;
        logic [4:0] exp_vb;

        rst_n = 1'b0;
        hz = 0; br = 0; mb = 0; ctrl_in = '0; hz_b = 0; br_b = 0;

        tbl[0] = mk(0, 0, 0, 10'h2A5, 4'b1101, 10'h2A5, 1);
        tbl[1] = mk(1, 0, 0, 10'h111, 4'b0001, 10'h000, 0);
        tbl[2] = mk(0, 0, 0, 10'h0F0, 4'b1101, 10'h0F0, 1);
        tbl[3] = mk(1, 1, 0, 10'h333, 4'b1111, 10'h000, 0);
        tbl[4] = mk(0, 0, 0, 10'h155, 4'b1101, 10'h155, 1);
        tbl[5] = mk(0, 0, 1, 10'h3FF, 4'b0000, 10'h155, 1);
        tbl[6] = mk(1, 1, 1, 10'h3FF, 4'b0000, 10'h155, 1);
        tbl[7] = mk(0, 0, 0, 10'h200, 4'b1101, 10'h200, 1);
        tbl[8] = mk(0, 1, 0, 10'h001, 4'b1111, 10'h000, 0);
        tbl[9] = mk(0, 0, 0, 10'h3C3, 4'b1101, 10'h3C3, 1);

        // Reset state
        #12;
        check("rst.en", {28'd0, pc_en, if_id_en, if_id_flush, ex_mem_en}, 32'd0);
        check("rst.ctrl_out", {22'd0, ctrl_out}, 32'd0);
        check("rst.valid", {31'd0, id_ex_valid}, 32'd0);
        check("rst.err", {31'd0, stall_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("tbl%0d", i));
        check("tbl.stall_cycles", {16'd0, stall_cycles}, PERF * 1);
        check("tbl.flush_events", {16'd0, flush_events}, PERF * 2);
        check("tbl.err", {31'd0, stall_err}, 32'd0);

        // Watchdog: 5 consecutive stalls, sets after the 4th, sticky
        for (int k = 0; k < 5; k++) begin
            step(mk(1, 0, 0, 10'h2AA, 4'b0001, 10'h000, 0), $sformatf("wd%0d", k));
            check($sformatf("wd%0d.err", k), {31'd0, stall_err}, (k >= 3) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            step(mk(0, 0, 0, 10'h0AB, 4'b1101, 10'h0AB, 1), $sformatf("wdrun%0d", k));
            check($sformatf("wdrun%0d.err", k), {31'd0, stall_err}, 32'd1);
        end
        do_reset();
        check("wdrst.err", {31'd0, stall_err}, 32'd0);

        // Freeze in the middle of a stall run
        step(mk(0, 0, 0, 10'h0AA, 4'b1101, 10'h0AA, 1), "fz.run");
        step(mk(1, 0, 0, 10'h0AA, 4'b0001, 10'h000, 0), "fz.st0");
        step(mk(1, 0, 0, 10'h0AA, 4'b0001, 10'h000, 0), "fz.st1");
        for (int k = 0; k < 3; k++) begin
            step(mk(1, 1, 1, 10'h3FF, 4'b0000, 10'h000, 0), $sformatf("fz.mb%0d", k));
            check($sformatf("fz.mb%0d.sc", k), {16'd0, stall_cycles}, PERF * 2);
            check($sformatf("fz.mb%0d.fe", k), {16'd0, flush_events}, 32'd0);
        end
        step(mk(1, 0, 0, 10'h0AA, 4'b0001, 10'h000, 0), "fz.st2");
        check("fz.st2.err", {31'd0, stall_err}, 32'd0);
        step(mk(1, 0, 0, 10'h0AA, 4'b0001, 10'h000, 0), "fz.st3");
        check("fz.st3.err", {31'd0, stall_err}, 32'd1);
        check("fz.sc", {16'd0, stall_cycles}, PERF * 4);

        // Asynchronous reset while frozen
        step(mk(0, 0, 0, 10'h155, 4'b1101, 10'h155, 1), "ar.run");
        @(negedge clk);
        mb = 1'b1;
        #1;
        check("ar.frozen_en", {28'd0, pc_en, if_id_en, if_id_flush, ex_mem_en}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.ctrl_out", {22'd0, ctrl_out}, 32'd0);
        check("ar.valid", {31'd0, id_ex_valid}, 32'd0);
        check("ar.err", {31'd0, stall_err}, 32'd0);
        check("ar.sc", {16'd0, stall_cycles}, 32'd0);
        mb = 1'b0;
        #1;
        check("ar.en", {28'd0, pc_en, if_id_en, if_id_flush, ex_mem_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // FLUSH_CYCLES=3 instance: flush exactly 3 cycles, hz_stall ignored while flushing
        exp_fl = 5'b00111;
        exp_vb = 5'b11000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            br_b = (k == 0);
            hz_b = (k == 1);
            #1;
            check($sformatf("fl3.c%0d.flush", k), {31'd0, if_id_flush_b}, {31'd0, exp_fl[k]});
            check($sformatf("fl3.c%0d.pc_en", k), {31'd0, pc_en_b}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("fl3.c%0d.valid", k), {31'd0, id_ex_valid_b}, {31'd0, exp_vb[k]});
        end
        check("fl3.fe", {16'd0, flush_events_b}, PERF * 1);
        check("fl3.sc", {16'd0, stall_cycles_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
